// File: rtl/rx_arbiter_if.sv
// Channel-side and FIFO-side signals of rx_arbiter. drop_cnt exists only when
// RX_ERR_DROP_EN is defined.
interface rx_arbiter_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0]   req;
  logic [8*NCH-1:0] ch_data;
  logic [NCH-1:0]   ch_perr;
  logic [NCH-1:0]   ch_ferr;
  logic [NCH-1:0]   ack;
  logic [7:0]       out_data;
  logic [2:0]       out_chan;
  logic [1:0]       out_err;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       fifo_count;
`ifdef RX_ERR_DROP_EN
  logic [15:0]      drop_cnt;

  modport slave (
    input  req, ch_data, ch_perr, ch_ferr, out_ready,
    output ack, out_data, out_chan, out_err, out_valid, fifo_count, drop_cnt
  );
  modport master (
    output req, ch_data, ch_perr, ch_ferr, out_ready,
    input  ack, out_data, out_chan, out_err, out_valid, fifo_count, drop_cnt
  );
`else
  modport slave (
    input  req, ch_data, ch_perr, ch_ferr, out_ready,
    output ack, out_data, out_chan, out_err, out_valid, fifo_count
  );
  modport master (
    output req, ch_data, ch_perr, ch_ferr, out_ready,
    input  ack, out_data, out_chan, out_err, out_valid, fifo_count
  );
`endif
endinterface

// File: rtl/rx_arbiter.sv
// Round-robin arbiter draining NCH receiver channels into a shared FIFO.
// Optional RX_ERR_DROP_EN: frames flagged with parity/frame errors are acked but dropped and counted.
module rx_arbiter #(
  parameter int NCH   = 4,
  parameter int DEPTH = 8
) (
  input  logic       RX_clk,
  input  logic       rst,
  rx_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ARB, WRITE} state_e;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [2:0] chan;
    logic [7:0] data;
  } entry_t;

  state_e        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  entry_t         wr_entry, head;
  logic [NCH-1:0] ack;
  logic [2:0]     pick;
  logic           found, write_go, drop, push, pop, valid;
  int             idx;

  // First requester at or after rr_ptr, wrapping to channel 0.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    idx   = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = 3'(idx);
      end
    end
  end

  // Fullness is judged on the registered count; a same-cycle pop does not help.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    write_go = 1'b0;
    case (state_q)
      ARB: begin
        if (found && (count_q < 5'(DEPTH))) begin
          grant_d = pick;
          state_d = WRITE;
        end
      end
      WRITE: begin
        write_go = 1'b1;
        rr_ptr_d = (grant_q == 3'(NCH - 1)) ? 3'd0 : grant_q + 3'd1;
        state_d  = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // Reset in the WRITE cycle suppresses the ack as well as the push.
  always_comb begin
    ack      = '0;
    wr_entry = '0;
    wr_entry.chan = grant_q;
    for (int k = 0; k < NCH; k++) begin
      if (grant_q == 3'(k)) begin
        ack[k]        = write_go && !rst;
        wr_entry.data = bus.ch_data[8*k +: 8];
        wr_entry.perr = bus.ch_perr[k];
        wr_entry.ferr = bus.ch_ferr[k];
      end
    end
  end

`ifdef RX_ERR_DROP_EN
  assign drop = wr_entry.perr | wr_entry.ferr;
`else
  assign drop = 1'b0;
`endif

  assign valid = (count_q != 5'd0);
  assign push  = write_go && !drop;
  assign pop   = valid && bus.out_ready;

  // A grant is only issued below DEPTH, so a push never meets a full FIFO.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + {4'd0, push} - {4'd0, pop};
  end

  always_ff @(posedge RX_clk) begin
    if (rst) begin
      state_q  <= ARB;
      grant_q  <= 3'd0;
      rr_ptr_q <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

`ifdef RX_ERR_DROP_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (write_go && drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge RX_clk) begin
    if (rst) drop_cnt_q <= 16'd0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

  assign head           = mem_q[rd_ptr_q];
  assign bus.ack        = ack;
  assign bus.out_valid  = valid;
  assign bus.out_data   = valid ? head.data : 8'd0;
  assign bus.out_chan   = valid ? head.chan : 3'd0;
  assign bus.out_err    = valid ? {head.ferr, head.perr} : 2'd0;
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_rx_arbiter.sv
// Scoreboard bench for rx_arbiter: expected FIFO entries are queued as frames are
// offered and compared on every pop; directed checks cover timing, fullness and reset.
module tb_rx_arbiter;
  localparam int NCH   = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_arbiter_if #(.NCH(NCH)) bus();

  rx_arbiter #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .RX_clk (clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [12:0] sb_q[$];
  logic [12:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input int ch);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (bus.ack[ch]) seen = 1'b1;
    end
    if (!seen) chk("ack_timeout", 32'(bus.ack), 32'(1 << ch));
  endtask

  // Pop side of the scoreboard: every accepted head must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("pop_unexpected", 32'({bus.out_err, bus.out_chan, bus.out_data}), 32'hDEAD_BEEF);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pop_entry", 32'({bus.out_err, bus.out_chan, bus.out_data}), 32'(mon_e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nacks;
    bit  bump;
    int  guard;

    bus.req       = '0;
    bus.ch_data   = '0;
    bus.ch_perr   = '0;
    bus.ch_ferr   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_ack",   32'(bus.ack),        32'd0);
    chk("rst_valid", 32'(bus.out_valid),  32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_out",   32'({bus.out_err, bus.out_chan, bus.out_data}), 32'd0);
`ifdef RX_ERR_DROP_EN
    chk("rst_drop",  32'(bus.drop_cnt),   32'd0);
`endif
    rst = 1'b0;

    // Single frame latency: ack at n+1, out_valid at n+2
    bus.out_ready = 1'b1;
    step();
    bus.req           = 4'b0001;
    bus.ch_data[7:0]  = 8'hA5;
    sb_q.push_back({2'b00, 3'd0, 8'hA5});
    #1 chk("lat_ack_n", 32'(bus.ack), 32'd0);
    step();
    chk("lat_ack_n1",   32'(bus.ack),       32'b0001);
    chk("lat_valid_n1", 32'(bus.out_valid), 32'd0);
    bus.req = '0;
    step();
    chk("lat_valid_n2", 32'(bus.out_valid), 32'd1);
    chk("lat_data",     32'(bus.out_data),  32'hA5);
    chk("lat_chan",     32'(bus.out_chan),  32'd0);
    chk("lat_err",      32'(bus.out_err),   32'd0);
    step();
    chk("lat_empty",    32'(bus.out_valid), 32'd0);

    // Round robin from a fresh rr_ptr with all channels held
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    for (int k = 0; k < NCH; k++) bus.ch_data[8*k +: 8] = 8'h10 + 8'(k);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) sb_q.push_back({2'b00, 3'(g % 4), 8'h10 + 8'(g % 4)});
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("rr_ack", 32'(bus.ack), (j % 2 == 1) ? 32'(1 << (((j - 1) / 2) % 4)) : 32'd0);
      if (j == 9) bus.req = '0;
    end

    // Fill to DEPTH from ch2, 9th request must wait for a pop plus one cycle
    step();
    step();
    step();
    bus.out_ready = 1'b0;
    bus.ch_data[23:16] = 8'h20;
    sb_q.push_back({2'b00, 3'd2, 8'h20});
    bus.req[2] = 1'b1;
    nacks = 0;
    bump  = 1'b0;
    for (int i = 0; i < 60 && nacks < 8; i++) begin
      step();
      if (bump) begin
        bump = 1'b0;
        bus.ch_data[23:16] = 8'h20 + 8'(nacks);
        sb_q.push_back({2'b00, 3'd2, 8'h20 + 8'(nacks)});
      end
      if (bus.ack[2]) begin
        nacks++;
        bump = 1'b1;
      end
    end
    chk("fill_acks", 32'(nacks), 32'd8);
    step();
    bus.ch_data[23:16] = 8'h28;
    sb_q.push_back({2'b00, 3'd2, 8'h28});
    chk("full_count", 32'(bus.fifo_count), 32'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_ack", 32'(bus.ack),        32'd0);
      chk("full_hold_cnt", 32'(bus.fifo_count), 32'd8);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("pop_count",  32'(bus.fifo_count), 32'd7);
    chk("no_bypass",  32'(bus.ack),        32'd0);
    step();
    chk("ninth_ack",  32'(bus.ack),        32'b0100);
    bus.req[2] = 1'b0;
    step();
    chk("refill_cnt", 32'(bus.fifo_count), 32'd8);
    bus.out_ready = 1'b1;
    guard = 0;
    while (bus.fifo_count != 5'd0 && guard < 30) begin
      step();
      guard++;
    end
    chk("drain", 32'(bus.fifo_count), 32'd0);

    // Frame error on ch1
    bus.ch_data[15:8] = 8'h3C;
    bus.ch_ferr[1]    = 1'b1;
    bus.req[1]        = 1'b1;
`ifndef RX_ERR_DROP_EN
    sb_q.push_back({2'b10, 3'd1, 8'h3C});
`endif
    wait_ack(1);
    bus.req[1] = 1'b0;
    step();
    bus.ch_ferr[1] = 1'b0;
    step();
    step();
    step();
`ifdef RX_ERR_DROP_EN
    chk("drop_cnt",   32'(bus.drop_cnt),   32'd1);
    chk("drop_valid", 32'(bus.out_valid),  32'd0);
    chk("drop_count", 32'(bus.fifo_count), 32'd0);
`else
    chk("err_popped", 32'(sb_q.size()),    32'd0);
`endif

    // Reset landing on a WRITE cycle with 3 entries queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ch_data[15:8] = 8'h40 + 8'(i);
      bus.req[1] = 1'b1;
      sb_q.push_back({2'b00, 3'd1, 8'h40 + 8'(i)});
      wait_ack(1);
      bus.req[1] = 1'b0;
      step();
    end
    chk("pre_rst_cnt", 32'(bus.fifo_count), 32'd3);
    bus.ch_data[23:16] = 8'h52;
    bus.req[2] = 1'b1;
    step();
    rst = 1'b1;
    #1 chk("rst_write_ack", 32'(bus.ack), 32'd0);
    step();
    rst = 1'b0;
    sb_q.delete();
    chk("rst_write_cnt",   32'(bus.fifo_count), 32'd0);
    chk("rst_write_valid", 32'(bus.out_valid),  32'd0);
    chk("rst_write_ack2",  32'(bus.ack),        32'd0);
    bus.ch_data[15:8] = 8'h51;
    bus.req = 4'b0110;
    sb_q.push_back({2'b00, 3'd1, 8'h51});
    step();
    chk("rr_after_rst", 32'(bus.ack), 32'b0010);
    bus.req = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rx_arbiter.md
RX_ARBITER -- requirements
Module: rx_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4: number of receiver channels (2..8).
REQ-002 SHALL have parameter DEPTH, default 8: shared FIFO entries (power of 2, 2..16).
REQ-003 SHALL have port RX_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port req, input, NCH: per-channel "frame held" level; stays high until acked.
REQ-006 SHALL have port ch_data, input, 8*NCH: channel k byte at bits [8k+7:8k].
REQ-007 SHALL have port ch_perr, input, NCH: per-channel parity warning, qualified by req.
REQ-008 SHALL have port ch_ferr, input, NCH: per-channel frame warning, qualified by req.
REQ-009 SHALL have port ack, output, NCH: one-hot, one-cycle consume pulse.
REQ-010 SHALL have port out_data, output, 8: FIFO head byte.
REQ-011 SHALL have port out_chan, output, 3: FIFO head source channel index.
REQ-012 SHALL have port out_err, output, 2: FIFO head flags {ferr, perr}.
REQ-013 SHALL have port out_valid, output, 1: FIFO non-empty.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts head when out_valid is also high.
REQ-015 SHALL have port fifo_count, output, 5: occupancy, 0..DEPTH.

Function
REQ-016 SHALL implement a 2-state FSM: ARB, then WRITE.
- ARB: if any req is high and fifo_count < DEPTH, register the grant index and go to WRITE.
- ARB otherwise: stay in ARB.
- WRITE: assert ack[grant] for exactly that cycle, push {ferr, perr, chan, data} sampled in that cycle, return to ARB.
REQ-017 SHALL choose the grant round-robin: first requesting channel at or after rr_ptr, wrapping NCH-1 to 0; rr_ptr becomes grant+1 mod NCH on each WRITE.
REQ-018 SHALL give latency: req sampled high in ARB cycle n, ack high in cycle n+1, out_valid high from cycle n+2 if the FIFO was empty.
REQ-019 SHALL pop the head on a cycle with out_valid and out_ready; out_data, out_chan and out_err SHALL show the next entry from the following cycle.
REQ-020 SHALL evaluate the full check in ARB on the registered fifo_count: a pop in the same cycle does not unblock the grant.
REQ-021 SHALL apply simultaneous push and pop in one cycle, leaving fifo_count unchanged.
REQ-022 SHALL keep the output fields stable while out_valid is high and out_ready is low.
REQ-023 SHALL ignore a pop while empty, with no pointer or count change.
REQ-024 SHALL wrap FIFO read and write pointers modulo DEPTH.
REQ-025 SHALL allow a channel whose req falls while in WRITE to still be acked and pushed; the requester owns that ordering.
REQ-026 SHALL never assert more than one ack bit per cycle.

Reset
REQ-027 SHALL set on rst high at a clock edge: FSM = ARB, rr_ptr = 0, pointers = 0, fifo_count = 0, ack = 0, out_valid = 0, out_data = 0, out_chan = 0, out_err = 0.
REQ-028 SHALL let rst asserted during WRITE cancel the pending ack and push, and discard all FIFO contents.

Configuration
REQ-029 SHALL support macro RX_ERR_DROP_EN.
- When defined: a WRITE whose sampled ch_perr or ch_ferr is high still asserts ack and advances rr_ptr, but does not push.
- When defined: a 16-bit saturating output drop_cnt SHALL count such frames and reset to 0.
- When undefined: all frames are pushed with their flags, and drop_cnt is absent.

Verification
REQ-030 SHALL cover: req=0001, ch0 byte 0xA5, no errors -> ack=0001 one cycle later; out_valid two cycles after req; out_data=0xA5, out_chan=0, out_err=00.
REQ-031 SHALL cover: req=1111 held, each channel re-requesting after ack, out_ready=1 -> ack order ch0, ch1, ch2, ch3, ch0, one grant every 2 cycles.
REQ-032 SHALL cover: out_ready=0, 8 frames from ch2 -> fifo_count=8; 9th req stays un-acked; out_ready=1 for one cycle -> count 7, then the 9th is acked.
REQ-033 SHALL cover: ch1 frame with ferr=1 -> out_err=10 with the macro undefined; no out_valid and drop_cnt=1 with RX_ERR_DROP_EN defined.
REQ-034 SHALL cover: rst pulsed in the WRITE cycle with 3 entries queued -> ack stays 0, fifo_count=0 and out_valid=0 next cycle, rr_ptr=0.
